pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Control unit driving the PC register of the vector CPU front end: generates its enable and next-value inputs from start, stall, branch and halt events. Sits between the hazard/branch logic and the PC register, closing the loop through the register's current value. Also produces a pipeline flush window after taken branches and a fetch-advance counter for debug.

## Interface
- WIDTH, 32, PC and counter width
- RESET_PC, 32'h0000_0000, PC loaded on start
- INSTR_BYTES, 4, sequential PC increment
- FLUSH_CYCLES, 2, flush window length in non-stalled cycles (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin execution from RESET_PC (honoured in IDLE/HALTED only)
- stall  in  1  hazard freeze; PC must not advance
- branch_taken  in  1  redirect request, one cycle
- branch_target  in  WIDTH  redirect address, valid with branch_taken
- halt  in  1  halt instruction decoded
- q_PC  in  WIDTH  current PC from PC register
- en  out  1  PC register enable
- d_PC  out  WIDTH  PC register next value
- flush  out  1  squash fetch/decode stage contents
- busy  out  1  high in RUN or FLUSH
- halted  out  1  high in HALTED
- fetch_count  out  WIDTH  number of PC advances since last start

## Operation
- States: IDLE, RUN, FLUSH, HALTED. Reset → IDLE, flush counter 0, fetch_count 0.
- en, d_PC, flush are combinational from state and inputs; busy, halted decode state.
- IDLE/HALTED: en=0, d_PC=RESET_PC, flush=0. start=1 → en=1, d_PC=RESET_PC, fetch_count cleared to 0, next RUN.
- RUN, priority halt > branch_taken > stall > sequential:
  - halt: en=0, next HALTED.
  - branch_taken: en=1, d_PC=branch_target, flush=1; if FLUSH_CYCLES>1 load counter FLUSH_CYCLES-1, next FLUSH, else stay RUN. Overrides stall.
  - stall: en=0, d_PC=q_PC.
  - else: en=1, d_PC=q_PC+INSTR_BYTES, truncated to WIDTH (wraps 0xFFFF_FFFC→0x0).
- FLUSH: flush=1; branch_taken and halt ignored (belong to squashed instructions); stall → en=0 and counter holds; else en=1, d_PC=q_PC+INSTR_BYTES, counter decrements; counter reaching 0 on that cycle → next RUN.
- fetch_count increments by 1 on every cycle with en=1 in RUN/FLUSH; the start load does not count; wraps at 2^WIDTH.
- start ignored in RUN/FLUSH. halt in IDLE/HALTED ignored.

## Timing
- Zero-cycle control: en/d_PC valid in the cycle the event is presented; q_PC shows the new value after the next rising edge.
- start at edge N → q_PC=RESET_PC after edge N+1, RESET_PC+4 after N+2.
- Taken branch: flush high for FLUSH_CYCLES non-stalled cycles, starting with the branch cycle.
- Halt: PC frozen from the halt cycle; halted=1 from next edge.
- rst asserted at any time (including mid-FLUSH): state IDLE, en=0, flush=0, busy=0, halted=0, fetch_count=0, d_PC=RESET_PC, immediately without clock edge. PC register shares rst, so q_PC=0.

## Test plan
- rst 5 cycles, then start pulse (RESET_PC=0x100) → en=0/busy=0 during reset; q_PC 0x100, 0x104, 0x108 on successive edges; fetch_count=2 at 0x108.
- stall held 3 cycles at q_PC=0x108 → en=0, q_PC stays 0x108, fetch_count unchanged; release → q_PC=0x10C next edge.
- branch_taken, target 0x200, at q_PC=0x10C (FLUSH_CYCLES=2) → q_PC=0x200, flush high 2 cycles; branch_taken to 0x300 in 2nd cycle ignored → q_PC=0x204.
- branch_taken and stall together → branch wins, q_PC=0x200; stall during FLUSH extends flush by the stalled cycles.
- halt at q_PC=0x208 → en=0, halted=1, q_PC frozen 10 cycles; start → q_PC=0x100, fetch_count=0, busy=1.
- sequential at q_PC=0xFFFF_FFFC → wraps to 0x0; async rst between edges in FLUSH → flush/busy drop immediately, state IDLE.

Source files
------------

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer : PC register control (start/stall/branch/halt, flush window)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_PC     = '0,
  parameter int               INSTR_BYTES  = 4,
  parameter int               FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             halt,
  input  logic [WIDTH-1:0] q_PC,
  output logic             en,
  output logic [WIDTH-1:0] d_PC,
  output logic             flush,
  output logic             busy,
  output logic             halted,
  output logic [WIDTH-1:0] fetch_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [WIDTH-1:0] fetch_count_q, fetch_count_d;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc = q_PC + WIDTH'(INSTR_BYTES);

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    fetch_count_d = fetch_count_q;
    en            = 1'b0;
    d_PC          = RESET_PC;
    flush         = 1'b0;
    // Outputs are combinational, so reset must mask them without a clock edge
    if (!rst) begin
      case (state_q)
        S_RUN: begin
          if (halt) begin
            d_PC    = q_PC;
            state_d = S_HALTED;
          end else if (branch_taken) begin
            en    = 1'b1;
            d_PC  = branch_target;
            flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              flush_cnt_d = CW'(FLUSH_CYCLES - 1);
              state_d     = S_FLUSH;
            end
          end else if (stall) begin
            d_PC = q_PC;
          end else begin
            en   = 1'b1;
            d_PC = pc_inc;
          end
        end
        S_FLUSH: begin
          flush = 1'b1;
          if (stall) begin
            d_PC = q_PC;
          end else begin
            en          = 1'b1;
            d_PC        = pc_inc;
            flush_cnt_d = flush_cnt_q - CW'(1);
            if (flush_cnt_q == CW'(1)) state_d = S_RUN;
          end
        end
        default: begin
          if (start) begin
            en            = 1'b1;
            fetch_count_d = '0;
            state_d       = S_RUN;
          end
        end
      endcase
      if (en && (state_q == S_RUN || state_q == S_FLUSH))
        fetch_count_d = fetch_count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      flush_cnt_q   <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign halted      = (state_q == S_HALTED);
  assign fetch_count = fetch_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer : randomized scoreboard bench for pc_sequencer
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] RESET_PC     = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stall = 1'b0, branch_taken = 1'b0, halt = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] q_PC;
  logic        en, flush, busy, halted;
  logic [31:0] d_PC, fetch_count;

  pc_sequencer #(
    .WIDTH(32), .RESET_PC(RESET_PC), .INSTR_BYTES(4), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .q_PC(q_PC), .en(en), .d_PC(d_PC), .flush(flush), .busy(busy),
    .halted(halted), .fetch_count(fetch_count)
  );

  // PC register sharing the sequencer's reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q_PC <= '0;
    else if (en) q_PC <= d_PC;
  end

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        chk_d;
    logic [31:0] d;
    logic        flush;
    logic        busy;
    logic        halted;
    logic [31:0] fc;
    logic [31:0] qpc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: execution status, remaining flush cycles, PC and fetch count
  bit          m_running = 0;
  bit          m_halted  = 0;
  int          m_flush_left = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("q_PC", q_PC, e.qpc);
      chk("en", {31'b0, en}, {31'b0, e.en});
      if (e.chk_d) chk("d_PC", d_PC, e.d);
      chk("flush", {31'b0, flush}, {31'b0, e.flush});
      chk("busy", {31'b0, busy}, {31'b0, e.busy});
      chk("halted", {31'b0, halted}, {31'b0, e.halted});
      chk("fetch_count", fetch_count, e.fc);
    end
  end

  task automatic model_reset();
    m_running = 0; m_halted = 0; m_flush_left = 0; m_pc = '0; m_cnt = '0;
  endtask

  // Apply one cycle of stimulus (called at posedge+1), push expectation, advance model
  task automatic cyc(input logic st, input logic sl, input logic bt,
                     input logic [31:0] tg, input logic hl);
    exp_t e;
    start = st; stall = sl; branch_taken = bt; branch_target = tg; halt = hl;
    e.qpc = m_pc; e.busy = m_running; e.halted = m_halted; e.fc = m_cnt;
    e.en = 0; e.chk_d = 1; e.d = RESET_PC; e.flush = 0;
    if (!m_running) begin
      if (st) begin
        e.en = 1;
        m_running = 1; m_halted = 0; m_cnt = '0; m_pc = RESET_PC; m_flush_left = 0;
      end
    end else if (m_flush_left > 0) begin
      e.flush = 1;
      if (sl) e.d = m_pc;
      else begin
        e.en = 1; e.d = m_pc + 32'd4;
        m_pc = m_pc + 32'd4; m_cnt++; m_flush_left--;
      end
    end else if (hl) begin
      e.chk_d = 0;
      m_running = 0; m_halted = 1;
    end else if (bt) begin
      e.en = 1; e.d = tg; e.flush = 1;
      m_pc = tg; m_cnt++; m_flush_left = FLUSH_CYCLES - 1;
    end else if (sl) begin
      e.d = m_pc;
    end else begin
      e.en = 1; e.d = m_pc + 32'd4;
      m_pc = m_pc + 32'd4; m_cnt++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    cyc(0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    // Reset held for 5 cycles; outputs must stay inactive
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      @(negedge clk);
      chk("rst_en", {31'b0, en}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 0; start = 0;
    model_reset();

    idle_cycle();
    cyc(1, 0, 0, 32'h0, 0);            // start
    idle_cycle();                      // 0x100 -> 0x104
    idle_cycle();                      // 0x104 -> 0x108
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'h0, 0);
    idle_cycle();                      // 0x108 -> 0x10C
    cyc(0, 1, 1, 32'h200, 0);          // branch wins over stall
    cyc(0, 1, 1, 32'h300, 1);          // stalled flush cycle, branch/halt ignored
    cyc(0, 0, 1, 32'h300, 1);          // last flush cycle -> 0x204
    idle_cycle();                      // 0x204 -> 0x208
    cyc(0, 0, 0, 32'h0, 1);            // halt
    for (int i = 0; i < 10; i++) cyc(0, i[0], i[1], 32'h500, 1);
    cyc(1, 0, 0, 32'h0, 0);            // restart
    idle_cycle();
    cyc(0, 0, 1, 32'hFFFF_FFF8, 0);    // approach the wrap point
    for (int i = 0; i < 4; i++) idle_cycle();

    for (int i = 0; i < 600; i++) begin
      logic st, sl, bt, hl;
      logic [31:0] tg;
      st = ($urandom_range(0, 9) == 0);
      sl = ($urandom_range(0, 3) == 0);
      bt = ($urandom_range(0, 5) == 0);
      hl = ($urandom_range(0, 39) == 0);
      tg = {$urandom} & 32'hFFFF_FFFC;
      cyc(st, sl, bt, tg, hl);
    end

    // Ensure running, then assert reset between edges inside a flush window
    cyc(1, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    if (!m_running) cyc(1, 0, 0, 32'h0, 0);
    while (m_flush_left > 0) idle_cycle();
    cyc(0, 0, 1, 32'h400, 0);
    start = 1; stall = 0; branch_taken = 0; halt = 0;
    #2;
    rst = 1;
    #1;
    chk("arst_en", {31'b0, en}, 32'd0);
    chk("arst_flush", {31'b0, flush}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_halted", {31'b0, halted}, 32'd0);
    chk("arst_fetch_count", fetch_count, 32'd0);
    chk("arst_d_PC", d_PC, RESET_PC);
    chk("arst_q_PC", q_PC, 32'd0);
    start = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_reset();
    idle_cycle();
    cyc(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 5; i++) idle_cycle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
